// File: rtl/psram_bist_pkg.sv
// Shared types and default timing for the PSRAM built-in self-test.
// Holds the FSM encoding, the pattern modes and the error-counter arithmetic.
package psram_bist_pkg;

   typedef enum logic [3:0] {
      ST_IDLE      = 4'd0,
      ST_INIT_WAIT = 4'd1,
      ST_WR_CMD    = 4'd2,
      ST_WR_BURST  = 4'd3,
      ST_WR_GAP    = 4'd4,
      ST_RD_CMD    = 4'd5,
      ST_RD_WAIT   = 4'd6,
      ST_RD_BURST  = 4'd7,
      ST_RD_GAP    = 4'd8,
      ST_DONE      = 4'd9
   } state_e;

   typedef enum logic [1:0] {
      MODE_FIXED    = 2'd0,
      MODE_ADDR     = 2'd1,
      MODE_INV_ADDR = 2'd2,
      MODE_WALK     = 2'd3
   } mode_e;

   localparam int DEF_INIT_WAIT  = 10;
   localparam int DEF_WR_GAP     = 14;
   localparam int DEF_RD_GAP     = 14;
   localparam int DEF_RD_TIMEOUT = 64;

   // Error counter add that sticks at all-ones instead of wrapping.
   function automatic logic [15:0] sat_add16(input logic [15:0] a, input logic [15:0] b);
      logic [16:0] sum;
      sum = {1'b0, a} + {1'b0, b};
      return sum[16] ? 16'hFFFF : sum[15:0];
   endfunction

endpackage

// File: rtl/psram_pattern_gen.sv
// Combinational data pattern for burst k, beat b at burst address a.
// Instantiated twice: once for write data, once for the expected read value.
module psram_pattern_gen
   import psram_bist_pkg::*;
#(
   parameter int ADDR_W      = 21,
   parameter int BURST_BEATS = 4
) (
   input  mode_e             mode,
   input  logic [31:0]       seed,
   input  logic [ADDR_W-1:0] a,
   input  logic [15:0]       k,
   input  logic [15:0]       b,
   output logic [63:0]       data
);

   logic [31:0] a_ext;
   logic [63:0] addr_pat;
   logic [5:0]  walk_idx;

   // NOTE: every always_comb output gets a default first, so no path can infer a latch.
   always_comb begin
      a_ext    = 32'(a);
      addr_pat = {seed ^ a_ext, 30'b0, b[1:0]};
      walk_idx = 6'(32'(k) * 32'(BURST_BEATS) + 32'(b));
      data     = '0;
      case (mode)
         MODE_FIXED:    data = {seed, ~seed};
         MODE_ADDR:     data = addr_pat;
         MODE_INV_ADDR: data = ~addr_pat;
         MODE_WALK:     data = 64'd1 << walk_idx;
         default:       data = '0;
      endcase
   end

endmodule

// File: rtl/psram_bist.sv
// PSRAM self-test: writes NUM_BURSTS patterned bursts, reads them back and
// compares, reporting error count, first failing address/data and timeout.
module psram_bist
   import psram_bist_pkg::*;
#(
   parameter int                ADDR_W      = 21,
   parameter int                DATA_W      = 64,
   parameter int                BURST_BEATS = 4,
   parameter int                NUM_BURSTS  = 16,
   parameter logic [ADDR_W-1:0] ADDR_STEP   = 'h20,
   parameter int                INIT_WAIT   = DEF_INIT_WAIT,
   parameter int                WR_GAP      = DEF_WR_GAP,
   parameter int                RD_GAP      = DEF_RD_GAP,
   parameter int                RD_TIMEOUT  = DEF_RD_TIMEOUT
) (
   input  logic              ext_clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic              abort,
   input  logic [1:0]        mode,
   input  logic [31:0]       seed,
   input  logic [ADDR_W-1:0] base_addr,
   input  logic              init_calib,
   output logic              cmd,
   output logic              cmd_en,
   output logic [ADDR_W-1:0] addr,
   output logic [DATA_W-1:0] wr_data,
   output logic [7:0]        data_mask,
   input  logic [DATA_W-1:0] rd_data,
   input  logic              rd_data_valid,
   output logic              busy,
   output logic              done,
   output logic              pass,
   output logic              timeout,
   output logic [15:0]       err_cnt,
   output logic [ADDR_W-1:0] fail_addr,
   output logic [DATA_W-1:0] fail_data,
   output logic [3:0]        state_dbg
);

   state_e            state;
   mode_e             mode_q;
   logic [31:0]       seed_q;
   logic [ADDR_W-1:0] base_q;
   logic [ADDR_W-1:0] cur_addr;
   logic [15:0]       cnt;
   logic [15:0]       k;
   logic [15:0]       beat;
   logic              have_fail;

   logic [ADDR_W-1:0] wg_addr;
   logic [15:0]       wg_k;
   logic [15:0]       wg_b;
   logic [63:0]       wg_data;
   logic [63:0]       exp_data;
   logic              is_busy;
   logic              stop;
   logic              last_burst;
   logic              cmp_fire;

   assign is_busy    = (state != ST_IDLE) && (state != ST_DONE);
   assign stop       = abort || (is_busy && !init_calib);
   assign last_burst = (k == 16'(NUM_BURSTS - 1));
   assign cmp_fire   = rd_data_valid && ((state == ST_RD_WAIT) || (state == ST_RD_BURST))
                       && (rd_data != exp_data);

   assign busy      = is_busy;
   assign done      = (state == ST_DONE);
   assign addr      = cur_addr;
   assign state_dbg = state;
   assign data_mask = 8'h00;

   // Write data is registered, so the generator looks one beat (or one burst) ahead.
   always_comb begin
      wg_addr = cur_addr;
      wg_k    = k;
      wg_b    = beat + 16'd1;
      if (state == ST_WR_GAP) begin
         wg_addr = cur_addr + ADDR_STEP;
         wg_k    = k + 16'd1;
         wg_b    = 16'd0;
      end else if (state == ST_INIT_WAIT) begin
         wg_b = 16'd0;
      end
   end

   psram_pattern_gen #(.ADDR_W(ADDR_W), .BURST_BEATS(BURST_BEATS)) u_wr_gen (
      .mode (mode_q),
      .seed (seed_q),
      .a    (wg_addr),
      .k    (wg_k),
      .b    (wg_b),
      .data (wg_data)
   );

   psram_pattern_gen #(.ADDR_W(ADDR_W), .BURST_BEATS(BURST_BEATS)) u_rd_gen (
      .mode (mode_q),
      .seed (seed_q),
      .a    (cur_addr),
      .k    (k),
      .b    (beat),
      .data (exp_data)
   );

   // NOTE: all state here uses non-blocking assignments so every register updates from pre-edge values.
   always_ff @(posedge ext_clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= ST_IDLE;
         mode_q    <= MODE_FIXED;
         seed_q    <= '0;
         base_q    <= '0;
         cur_addr  <= '0;
         cnt       <= '0;
         k         <= '0;
         beat      <= '0;
         have_fail <= 1'b0;
         cmd       <= 1'b0;
         cmd_en    <= 1'b0;
         wr_data   <= '0;
         pass      <= 1'b0;
         timeout   <= 1'b0;
         err_cnt   <= '0;
         fail_addr <= '0;
         fail_data <= '0;
      end else if (stop) begin
         state  <= ST_IDLE;
         cmd    <= 1'b0;
         cmd_en <= 1'b0;
      end else begin
         case (state)
            ST_IDLE, ST_DONE: begin
               if (start && init_calib) begin
                  state     <= ST_INIT_WAIT;
                  mode_q    <= mode_e'(mode);
                  seed_q    <= seed;
                  base_q    <= base_addr;
                  cur_addr  <= base_addr;
                  cnt       <= '0;
                  k         <= '0;
                  beat      <= '0;
                  have_fail <= 1'b0;
                  pass      <= 1'b0;
                  timeout   <= 1'b0;
                  err_cnt   <= '0;
                  fail_addr <= '0;
                  fail_data <= '0;
               end
            end
            ST_INIT_WAIT: begin
               if (cnt == 16'(INIT_WAIT - 1)) begin
                  state   <= ST_WR_CMD;
                  cmd     <= 1'b1;
                  cmd_en  <= 1'b1;
                  wr_data <= wg_data;
                  beat    <= '0;
               end else begin
                  cnt <= cnt + 16'd1;
               end
            end
            ST_WR_CMD: begin
               cmd_en <= 1'b0;
               if (BURST_BEATS > 1) begin
                  state   <= ST_WR_BURST;
                  wr_data <= wg_data;
                  beat    <= beat + 16'd1;
               end else begin
                  state <= ST_WR_GAP;
                  cnt   <= '0;
               end
            end
            ST_WR_BURST: begin
               if (beat == 16'(BURST_BEATS - 1)) begin
                  state <= ST_WR_GAP;
                  cnt   <= '0;
               end else begin
                  wr_data <= wg_data;
                  beat    <= beat + 16'd1;
               end
            end
            ST_WR_GAP: begin
               if (cnt == 16'(WR_GAP - 1)) begin
                  if (!last_burst) begin
                     state    <= ST_WR_CMD;
                     k        <= k + 16'd1;
                     cur_addr <= cur_addr + ADDR_STEP;
                     cmd      <= 1'b1;
                     cmd_en   <= 1'b1;
                     wr_data  <= wg_data;
                     beat     <= '0;
                  end else begin
                     state    <= ST_RD_CMD;
                     k        <= '0;
                     cur_addr <= base_q;
                     cmd      <= 1'b0;
                     cmd_en   <= 1'b1;
                  end
               end else begin
                  cnt <= cnt + 16'd1;
               end
            end
            ST_RD_CMD: begin
               state  <= ST_RD_WAIT;
               cmd_en <= 1'b0;
               beat   <= '0;
               cnt    <= '0;
            end
            ST_RD_WAIT: begin
               if (rd_data_valid) begin
                  if (BURST_BEATS > 1) begin
                     state <= ST_RD_BURST;
                     beat  <= 16'd1;
                  end else begin
                     state <= ST_RD_GAP;
                     cnt   <= '0;
                  end
               end else if (cnt == 16'(RD_TIMEOUT - 1)) begin
                  state   <= ST_DONE;
                  timeout <= 1'b1;
                  pass    <= 1'b0;
                  err_cnt <= sat_add16(err_cnt, 16'(BURST_BEATS));
               end else begin
                  cnt <= cnt + 16'd1;
               end
            end
            ST_RD_BURST: begin
               if (rd_data_valid) begin
                  if (beat == 16'(BURST_BEATS - 1)) begin
                     state <= ST_RD_GAP;
                     cnt   <= '0;
                  end else begin
                     beat <= beat + 16'd1;
                  end
               end else begin
                  // Burst ended early: every beat not delivered counts as an error.
                  state   <= ST_RD_GAP;
                  cnt     <= '0;
                  err_cnt <= sat_add16(err_cnt, 16'(BURST_BEATS) - beat);
               end
            end
            ST_RD_GAP: begin
               if (cnt == 16'(RD_GAP - 1)) begin
                  if (!last_burst) begin
                     state    <= ST_RD_CMD;
                     k        <= k + 16'd1;
                     cur_addr <= cur_addr + ADDR_STEP;
                     cmd      <= 1'b0;
                     cmd_en   <= 1'b1;
                  end else begin
                     state <= ST_DONE;
                     pass  <= (err_cnt == 16'd0) && !timeout;
                  end
               end else begin
                  cnt <= cnt + 16'd1;
               end
            end
            default: state <= ST_IDLE;
         endcase

         if (cmp_fire) begin
            err_cnt <= sat_add16(err_cnt, 16'd1);
            if (!have_fail) begin
               have_fail <= 1'b1;
               fail_addr <= cur_addr;
               fail_data <= rd_data;
            end
         end
      end
   end

endmodule

// File: tb/tb_psram_bist.sv
// Self-checking bench for psram_bist: a PSRAM model with fault knobs plus a
// scoreboard of expected write beats pushed when each run is started.
module tb_psram_bist;
   import psram_bist_pkg::*;

   localparam int BB = 4;
   localparam int NB = 16;

   logic        ext_clk;
   logic        rst_n;
   logic        start;
   logic        abort;
   logic [1:0]  mode;
   logic [31:0] seed;
   logic [20:0] base_addr;
   logic        init_calib;
   logic        cmd;
   logic        cmd_en;
   logic [20:0] addr;
   logic [63:0] wr_data;
   logic [7:0]  data_mask;
   logic [63:0] rd_data;
   logic        rd_data_valid;
   logic        busy;
   logic        done;
   logic        pass;
   logic        timeout;
   logic [15:0] err_cnt;
   logic [20:0] fail_addr;
   logic [63:0] fail_data;
   logic [3:0]  state_dbg;

   psram_bist dut (
      .ext_clk       (ext_clk),
      .rst_n         (rst_n),
      .start         (start),
      .abort         (abort),
      .mode          (mode),
      .seed          (seed),
      .base_addr     (base_addr),
      .init_calib    (init_calib),
      .cmd           (cmd),
      .cmd_en        (cmd_en),
      .addr          (addr),
      .wr_data       (wr_data),
      .data_mask     (data_mask),
      .rd_data       (rd_data),
      .rd_data_valid (rd_data_valid),
      .busy          (busy),
      .done          (done),
      .pass          (pass),
      .timeout       (timeout),
      .err_cnt       (err_cnt),
      .fail_addr     (fail_addr),
      .fail_data     (fail_data),
      .state_dbg     (state_dbg)
   );

   initial ext_clk = 1'b0;
   always #5 ext_clk = ~ext_clk;

   typedef struct {
      logic [20:0] addr;
      logic [63:0] data;
   } beat_t;

   int          tests_run    = 0;
   int          tests_failed = 0;
   beat_t       exp_q[$];
   logic [20:0] wcmd_addr[$];
   logic [63:0] mem [int];
   int          sb_on = 0;
   int          wr_beats = 0;
   int          wr_left = 0;
   int          wr_b = 0;
   logic [20:0] wr_a = '0;
   int          rd_idx = 0;
   int          rd_cur = 0;
   int          rd_delay = 0;
   int          rd_left = 0;
   int          rd_b = 0;
   logic [20:0] rd_a = '0;
   logic [63:0] rd_d;
   int          silent = 0;
   int          flip_burst = -1;
   int          flip_beat = -1;
   int          short_burst = -1;
   int          short_len = 0;
   int          long_burst = -1;

   function automatic int key_of(input logic [20:0] a, input int b);
      logic [1:0] bl;
      bl = b[1:0];
      return int'({a, bl});
   endfunction

   function automatic logic [63:0] exp_pat(input logic [1:0] m, input logic [31:0] s,
                                           input logic [20:0] a, input int k, input int b);
      logic [63:0] ap;
      logic [1:0]  bl;
      int          idx;
      bl  = b[1:0];
      ap  = {s ^ {11'b0, a}, 30'b0, bl};
      idx = (k * BB + b) % 64;
      case (m)
         2'd0:    return {s, ~s};
         2'd1:    return ap;
         2'd2:    return ~ap;
         default: return 64'd1 << idx;
      endcase
   endfunction

   task automatic model_write(input logic [20:0] a, input int b, input logic [63:0] d);
      beat_t e;
      mem[key_of(a, b)] = d;
      wr_beats++;
      if (sb_on != 0) begin
         tests_run++;
         if (exp_q.size() == 0) begin
            tests_failed++;
            $display("FAIL sb_extra_write: got addr=%h beat=%0d data=%h, expected no further beats", a, b, d);
         end else begin
            e = exp_q.pop_front();
            if (e.addr !== a || e.data !== d) begin
               tests_failed++;
               $display("FAIL sb_write_beat: got addr=%h data=%h, expected addr=%h data=%h", a, d, e.addr, e.data);
            end
         end
      end
   endtask

   // PSRAM model: captures write bursts, returns read bursts after a short latency.
   always @(negedge ext_clk) begin
      if (wr_left > 0) begin
         model_write(wr_a, wr_b, wr_data);
         wr_b++;
         wr_left--;
      end
      if (cmd_en && cmd) begin
         wcmd_addr.push_back(addr);
         wr_a = addr;
         model_write(addr, 0, wr_data);
         wr_b    = 1;
         wr_left = BB - 1;
      end
      rd_data_valid = 1'b0;
      if (rd_left > 0) begin
         if (rd_delay > 0) begin
            rd_delay--;
         end else begin
            rd_d = mem.exists(key_of(rd_a, rd_b)) ? mem[key_of(rd_a, rd_b)] : 64'h0;
            if (rd_cur == flip_burst && rd_b == flip_beat) rd_d = rd_d ^ 64'd1;
            rd_data       = rd_d;
            rd_data_valid = 1'b1;
            rd_b++;
            rd_left--;
         end
      end
      if (cmd_en && !cmd) begin
         rd_a     = addr;
         rd_cur   = rd_idx;
         rd_idx++;
         rd_b     = 0;
         rd_delay = 2;
         if (silent != 0)              rd_left = 0;
         else if (rd_cur == short_burst) rd_left = short_len;
         else if (rd_cur == long_burst)  rd_left = BB + 1;
         else                            rd_left = BB;
      end
   end

   task automatic clear_model();
      silent      = 0;
      flip_burst  = -1;
      flip_beat   = -1;
      short_burst = -1;
      long_burst  = -1;
      rd_idx      = 0;
      wr_beats    = 0;
      exp_q.delete();
      wcmd_addr.delete();
   endtask

   task automatic push_expected(input logic [1:0] m, input logic [31:0] s, input logic [20:0] b);
      logic [20:0] a;
      for (int kk = 0; kk < NB; kk++) begin
         a = b + 21'(kk * 32);
         for (int bb = 0; bb < BB; bb++) exp_q.push_back('{a, exp_pat(m, s, a, kk, bb)});
      end
   endtask

   task automatic do_start(input logic [1:0] m, input logic [31:0] s, input logic [20:0] b);
      @(negedge ext_clk);
      mode      = m;
      seed      = s;
      base_addr = b;
      start     = 1'b1;
      @(negedge ext_clk);
      start = 1'b0;
   endtask

   task automatic wait_done(input int bound, input string tag);
      int n = 0;
      while (!done && n < bound) begin
         @(negedge ext_clk);
         n++;
      end
      tests_run++;
      if (!done) begin
         tests_failed++;
         $display("FAIL %s_done_wait: got done=0 after %0d cycles, expected done=1", tag, bound);
      end
   endtask

   task automatic wait_state(input state_e st, input int bound, input string tag);
      int n = 0;
      while (state_dbg !== st && n < bound) begin
         @(negedge ext_clk);
         n++;
      end
      tests_run++;
      if (state_dbg !== st) begin
         tests_failed++;
         $display("FAIL %s_state_wait: got state=%0d, expected %0d", tag, state_dbg, st);
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (3) @(negedge ext_clk);
      tests_run++;
      if ({cmd, cmd_en, addr, wr_data, busy, done, pass, timeout, err_cnt, fail_addr, fail_data, state_dbg} !== '0) begin
         tests_failed++;
         $display("FAIL reset_outputs: got cmd_en=%b addr=%h busy=%b done=%b err=%h state=%0d, expected all 0",
                  cmd_en, addr, busy, done, err_cnt, state_dbg);
      end
      tests_run++;
      if (data_mask !== 8'h00) begin
         tests_failed++;
         $display("FAIL reset_data_mask: got %h, expected 00", data_mask);
      end
      rst_n = 1'b1;
      repeat (2) @(negedge ext_clk);
      tests_run++;
      if (state_dbg !== ST_IDLE) begin
         tests_failed++;
         $display("FAIL reset_idle: got state=%0d, expected 0", state_dbg);
      end
   endtask

   task automatic test_fixed_pass();
      clear_model();
      push_expected(2'd0, 32'hDEADBEEF, 21'h20);
      sb_on = 1;
      do_start(2'd0, 32'hDEADBEEF, 21'h20);
      tests_run++;
      if (busy !== 1'b1) begin
         tests_failed++;
         $display("FAIL fixed_busy: got %b, expected 1", busy);
      end
      wait_done(3000, "fixed");
      sb_on = 0;
      tests_run++;
      if (pass !== 1'b1 || err_cnt !== 16'd0 || timeout !== 1'b0 || busy !== 1'b0) begin
         tests_failed++;
         $display("FAIL fixed_status: got pass=%b err=%0d timeout=%b busy=%b, expected 1/0/0/0", pass, err_cnt, timeout, busy);
      end
      tests_run++;
      if (wr_beats != NB * BB || exp_q.size() != 0) begin
         tests_failed++;
         $display("FAIL fixed_beats: got %0d beats written, %0d unmatched, expected 64 and 0", wr_beats, exp_q.size());
      end
   endtask

   task automatic test_single_bit();
      logic [63:0] want;
      clear_model();
      flip_burst = 3;
      flip_beat  = 2;
      push_expected(2'd1, 32'h12345678, 21'h20);
      sb_on = 1;
      do_start(2'd1, 32'h12345678, 21'h20);
      wait_done(3000, "single");
      sb_on = 0;
      want = exp_pat(2'd1, 32'h12345678, 21'h80, 3, 2) ^ 64'd1;
      tests_run++;
      if (err_cnt !== 16'd1 || pass !== 1'b0) begin
         tests_failed++;
         $display("FAIL single_err: got err=%0d pass=%b, expected 1/0", err_cnt, pass);
      end
      tests_run++;
      if (fail_addr !== 21'h80) begin
         tests_failed++;
         $display("FAIL single_fail_addr: got %h, expected 000080", fail_addr);
      end
      tests_run++;
      if (fail_data !== want) begin
         tests_failed++;
         $display("FAIL single_fail_data: got %h, expected %h", fail_data, want);
      end
   endtask

   task automatic test_wrap();
      clear_model();
      push_expected(2'd2, 32'hA5A50F0F, 21'h1FFFF0);
      sb_on = 1;
      do_start(2'd2, 32'hA5A50F0F, 21'h1FFFF0);
      wait_done(3000, "wrap");
      sb_on = 0;
      tests_run++;
      if (wcmd_addr.size() < 2 || wcmd_addr[1] !== 21'h000010) begin
         tests_failed++;
         $display("FAIL wrap_second_addr: got %h (cmds=%0d), expected 000010",
                  (wcmd_addr.size() > 1) ? wcmd_addr[1] : 21'h0, wcmd_addr.size());
      end
      tests_run++;
      if (pass !== 1'b1 || err_cnt !== 16'd0) begin
         tests_failed++;
         $display("FAIL wrap_pass: got pass=%b err=%0d, expected 1/0", pass, err_cnt);
      end
   endtask

   task automatic test_walk_short_long();
      clear_model();
      short_burst = 5;
      short_len   = 2;
      long_burst  = 7;
      push_expected(2'd3, 32'h0, 21'h40);
      sb_on = 1;
      do_start(2'd3, 32'h0, 21'h40);
      wait_done(3000, "walk");
      sb_on = 0;
      tests_run++;
      if (err_cnt !== 16'd2 || pass !== 1'b0 || timeout !== 1'b0) begin
         tests_failed++;
         $display("FAIL walk_short_err: got err=%0d pass=%b timeout=%b, expected 2/0/0", err_cnt, pass, timeout);
      end
      tests_run++;
      if (fail_addr !== 21'h0 || fail_data !== 64'h0) begin
         tests_failed++;
         $display("FAIL walk_no_capture: got fail_addr=%h fail_data=%h, expected 0/0", fail_addr, fail_data);
      end
   endtask

   task automatic test_timeout();
      int n = 0;
      clear_model();
      silent = 1;
      do_start(2'd0, 32'h55AA55AA, 21'h0);
      while (!(cmd_en && !cmd) && n < 1000) begin
         @(negedge ext_clk);
         n++;
      end
      tests_run++;
      if (!(cmd_en && !cmd)) begin
         tests_failed++;
         $display("FAIL timeout_rd_cmd: got no read command within 1000 cycles, expected one");
      end
      n = 0;
      while (!done && n < 200) begin
         @(negedge ext_clk);
         n++;
      end
      // One RD_CMD cycle, then RD_TIMEOUT silent RD_WAIT cycles, then DONE.
      tests_run++;
      if (n != 65) begin
         tests_failed++;
         $display("FAIL timeout_latency: got done %0d cycles after RD_CMD, expected 65", n);
      end
      tests_run++;
      if (timeout !== 1'b1 || err_cnt !== 16'd4 || pass !== 1'b0) begin
         tests_failed++;
         $display("FAIL timeout_status: got timeout=%b err=%0d pass=%b, expected 1/4/0", timeout, err_cnt, pass);
      end
   endtask

   task automatic test_abort();
      clear_model();
      do_start(2'd0, 32'h1, 21'h20);
      wait_state(ST_WR_BURST, 100, "abort");
      abort = 1'b1;
      @(negedge ext_clk);
      abort = 1'b0;
      tests_run++;
      if (state_dbg !== ST_IDLE || cmd_en !== 1'b0 || done !== 1'b0 || busy !== 1'b0) begin
         tests_failed++;
         $display("FAIL abort_wr_burst: got state=%0d cmd_en=%b done=%b busy=%b, expected 0/0/0/0",
                  state_dbg, cmd_en, done, busy);
      end
      @(negedge ext_clk);
      start = 1'b1;
      abort = 1'b1;
      @(negedge ext_clk);
      start = 1'b0;
      abort = 1'b0;
      tests_run++;
      if (state_dbg !== ST_IDLE) begin
         tests_failed++;
         $display("FAIL abort_priority: got state=%0d, expected 0", state_dbg);
      end
      init_calib = 1'b0;
      do_start(2'd0, 32'h2, 21'h20);
      @(negedge ext_clk);
      tests_run++;
      if (state_dbg !== ST_IDLE || busy !== 1'b0) begin
         tests_failed++;
         $display("FAIL start_no_calib: got state=%0d busy=%b, expected 0/0", state_dbg, busy);
      end
      init_calib = 1'b1;
      do_start(2'd0, 32'h3, 21'h20);
      wait_state(ST_WR_GAP, 100, "calib_drop");
      init_calib = 1'b0;
      @(negedge ext_clk);
      tests_run++;
      if (state_dbg !== ST_IDLE || cmd_en !== 1'b0) begin
         tests_failed++;
         $display("FAIL calib_drop: got state=%0d cmd_en=%b, expected 0/0", state_dbg, cmd_en);
      end
      init_calib = 1'b1;
   endtask

   task automatic test_reset_mid();
      clear_model();
      flip_burst = 0;
      flip_beat  = 0;
      do_start(2'd1, 32'hCAFEF00D, 21'h20);
      wait_state(ST_RD_BURST, 1000, "reset_mid");
      tests_run++;
      if (err_cnt !== 16'd1) begin
         tests_failed++;
         $display("FAIL reset_mid_pre_err: got err=%0d, expected 1", err_cnt);
      end
      rst_n = 1'b0;
      #1;
      tests_run++;
      if ({cmd, cmd_en, addr, wr_data, busy, done, pass, timeout, err_cnt, fail_addr, fail_data, state_dbg} !== '0) begin
         tests_failed++;
         $display("FAIL reset_mid_outputs: got addr=%h err=%h fail_addr=%h state=%0d, expected all 0",
                  addr, err_cnt, fail_addr, state_dbg);
      end
      @(negedge ext_clk);
      rst_n = 1'b1;
      repeat (5) @(negedge ext_clk);
      tests_run++;
      if (state_dbg !== ST_IDLE || cmd_en !== 1'b0 || busy !== 1'b0) begin
         tests_failed++;
         $display("FAIL reset_mid_after: got state=%0d cmd_en=%b busy=%b, expected 0/0/0", state_dbg, cmd_en, busy);
      end
   endtask

   initial begin
      rst_n         = 1'b0;
      start         = 1'b0;
      abort         = 1'b0;
      mode          = 2'd0;
      seed          = '0;
      base_addr     = '0;
      init_calib    = 1'b1;
      rd_data       = '0;
      rd_data_valid = 1'b0;

      test_reset();
      test_fixed_pass();
      test_single_bit();
      test_wrap();
      test_walk_short_long();
      test_timeout();
      test_abort();
      test_reset_mid();

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
